// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcode/funct constants, ALU op codes and immediate helpers
package rv32i_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_XOR  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
   typedef enum logic [1:0] {B_REG, B_IMM_I, B_IMM_U} b_sel_e;

   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] instr);
      return {instr[31:12], 12'b0};
   endfunction

   // funct3 → op for the encodings where funct7 is all zero (slt has no code here)
   function automatic logic [3:0] base_op(input logic [2:0] funct3);
      case (funct3)
         F3_SLL:  return ALU_SLL;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return ALU_SRL;
         F3_OR:   return ALU_OR;
         F3_AND:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational RV32I ALU-class decode to alu_op, operand selects and illegal flag
module alu_op_decode
   import rv32i_pkg::*;
#(
   parameter real T = 0.0
) (
   input  logic [31:0] instr,
   output logic [3:0]  alu_op,
   output a_sel_e      a_sel,
   output b_sel_e      b_sel,
   output logic        illegal
);

   // T is carried for delay back-annotation only; no logic depends on it
   localparam real unused_t = T;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   // decode opcode/funct fields; anything unrecognised falls through as illegal with add and zero operand
   always_comb begin
      a_sel   = A_ZERO;
      b_sel   = B_REG;
      alu_op  = ALU_ADD;
      illegal = 1'b1;
      case (opcode)
         OPC_OP: begin
            a_sel = A_RS1;
            if (funct7 == F7_BASE && funct3 != F3_SLT) begin
               alu_op  = base_op(funct3);
               illegal = 1'b0;
            end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
               alu_op  = (funct3 == F3_ADD) ? ALU_SUB : ALU_SRA;
               illegal = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            a_sel = A_RS1;
            b_sel = B_IMM_I;
            if (funct3 == F3_SR && funct7 == F7_ALT) begin
               alu_op  = ALU_SRA;
               illegal = 1'b0;
            end else if (funct3 != F3_SLT && !((funct3 == F3_SLL || funct3 == F3_SR) && funct7 != F7_BASE)) begin
               alu_op  = base_op(funct3);
               illegal = 1'b0;
            end
         end
         OPC_LUI: begin
            b_sel   = B_IMM_U;
            illegal = 1'b0;
         end
         OPC_AUIPC: begin
            a_sel   = A_PC;
            b_sel   = B_IMM_U;
            illegal = 1'b0;
         end
         default: ;
      endcase
      if (illegal) begin
         a_sel  = A_ZERO;
         alu_op = ALU_ADD;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage registering ALU operands and op behind a valid/ready handshake
module alu_issue_stage
   import rv32i_pkg::*;
#(
   parameter real T = 0.0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   output logic [4:0]  rd,
   output logic        wb_en,
   output logic        illegal
);

   logic [3:0]  dec_op;
   a_sel_e      a_sel;
   b_sel_e      b_sel;
   logic        dec_illegal;
   logic        accept;
   logic [31:0] a_mux;
   logic [31:0] b_mux;

   alu_op_decode #(.T(T)) u_dec (
      .instr   (instr),
      .alu_op  (dec_op),
      .a_sel   (a_sel),
      .b_sel   (b_sel),
      .illegal (dec_illegal)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign a_mux    = (a_sel == A_RS1) ? rs1_data : (a_sel == A_PC) ? pc : '0;
   assign b_mux    = dec_illegal ? '0 : (b_sel == B_IMM_I) ? imm_i(instr) : (b_sel == B_IMM_U) ? imm_u(instr) : rs2_data;

   // stage register: holds while stalled, reloads on accept, flush drops the entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         rd        <= '0;
         wb_en     <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         out_valid <= !flush && (accept || (out_valid && !out_ready));
         if (accept) begin
            alu_a   <= a_mux;
            alu_b   <= b_mux;
            alu_op  <= dec_op;
            rd      <= instr[11:7];
            wb_en   <= !dec_illegal && (instr[11:7] != 5'd0);
            illegal <= dec_illegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        wb;
      logic        ill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [4:0]  rd;
   logic        wb_en;
   logic        illegal;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_push = 0;
   int   n_out = 0;
   vec_t tbl[16];
   vec_t cur;
   vec_t sb[$];

   alu_issue_stage #(.T(0.0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .rd        (rd),
      .wb_en     (wb_en),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input int i);
      bit ok = 0;
      in_valid = 1'b1;
      instr    = tbl[i].instr;
      pc       = tbl[i].pc;
      rs1_data = tbl[i].rs1;
      rs2_data = tbl[i].rs2;
      cur      = tbl[i];
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   // scoreboard: pop on a consuming edge, push on an accepting edge that is not flushed
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
               vec_t e;
               e = sb.pop_front();
               n_out++;
               chk($sformatf("a[%0d]", n_out), alu_a, e.a);
               chk($sformatf("b[%0d]", n_out), alu_b, e.b);
               chk($sformatf("op[%0d]", n_out), 32'(alu_op), 32'(e.op));
               chk($sformatf("rd[%0d]", n_out), 32'(rd), 32'(e.rd));
               chk($sformatf("wb[%0d]", n_out), 32'(wb_en), 32'(e.wb));
               chk($sformatf("ill[%0d]", n_out), 32'(illegal), 32'(e.ill));
            end
         end
         if (in_valid && in_ready && !flush) begin
            sb.push_back(cur);
            n_push++;
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_a"}, alu_a, 32'd0);
      chk({tag, "_b"}, alu_b, 32'd0);
      chk({tag, "_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_rd"}, 32'(rd), 32'd0);
      chk({tag, "_wb"}, 32'(wb_en), 32'd0);
      chk({tag, "_ill"}, 32'(illegal), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{32'h40208133, 32'h0,   32'h7,        32'h3,    32'h7,        32'h3,        4'd1, 5'd2,  1'b1, 1'b0};
      tbl[1]  = '{32'h4051D193, 32'h0,   32'h80000000, 32'h1234, 32'h80000000, 32'h405,      4'd7, 5'd3,  1'b1, 1'b0};
      tbl[2]  = '{32'hFFF08093, 32'h0,   32'h10,       32'h9,    32'h10,       32'hFFFFFFFF, 4'd0, 5'd1,  1'b1, 1'b0};
      tbl[3]  = '{32'h12345097, 32'h100, 32'h77,       32'h88,   32'h100,      32'h12345000, 4'd0, 5'd1,  1'b1, 1'b0};
      tbl[4]  = '{32'h0020A033, 32'h0,   32'h5,        32'h6,    32'h0,        32'h0,        4'd0, 5'd0,  1'b0, 1'b1};
      tbl[5]  = '{32'hABCDE2B7, 32'h0,   32'h55,       32'h66,   32'h0,        32'hABCDE000, 4'd0, 5'd5,  1'b1, 1'b0};
      tbl[6]  = '{32'h0062B233, 32'h0,   32'h1,        32'h2,    32'h1,        32'h2,        4'd8, 5'd4,  1'b1, 1'b0};
      tbl[7]  = '{32'h009473B3, 32'h0,   32'hF0F0,     32'hFF00, 32'hF0F0,     32'hFF00,     4'd4, 5'd7,  1'b1, 1'b0};
      tbl[8]  = '{32'h40309093, 32'h0,   32'h3,        32'h4,    32'h0,        32'h0,        4'd0, 5'd1,  1'b0, 1'b1};
      tbl[9]  = '{32'h0045D513, 32'h0,   32'h100,      32'h5,    32'h100,      32'h4,        4'd6, 5'd10, 1'b1, 1'b0};
      tbl[10] = '{32'h8006C613, 32'h0,   32'hA,        32'h0,    32'hA,        32'hFFFFF800, 4'd2, 5'd12, 1'b1, 1'b0};
      tbl[11] = '{32'h00208033, 32'h0,   32'h1,        32'h2,    32'h1,        32'h2,        4'd0, 5'd0,  1'b0, 1'b0};
      tbl[12] = '{32'h0020A023, 32'h40,  32'h1,        32'h2,    32'h0,        32'h0,        4'd0, 5'd0,  1'b0, 1'b1};
      tbl[13] = '{32'h4020E733, 32'h0,   32'h1,        32'h2,    32'h0,        32'h0,        4'd0, 5'd14, 1'b0, 1'b1};
      tbl[14] = '{32'h002097B3, 32'h0,   32'h9,        32'h3,    32'h9,        32'h3,        4'd5, 5'd15, 1'b1, 1'b0};
      tbl[15] = '{32'h4020D833, 32'h0,   32'hF0000000, 32'h4,    32'hF0000000, 32'h4,        4'd7, 5'd16, 1'b1, 1'b0};

      #12;
      chk_reset("rst0");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      fork
         begin
            for (int i = 0; i < 4; i++) send(i);
            in_valid = 1'b0;
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_a", alu_a, tbl[1].a);
               chk("stall_b", alu_b, tbl[1].b);
               chk("stall_op", 32'(alu_op), 32'(tbl[1].op));
               @(posedge clk);
            end
            #1;
            out_ready = 1'b1;
         end
      join

      for (int i = 4; i < 16; i++) send(i);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      send(0);
      flush = 1'b1;
      send(5);
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      send(6);
      in_valid = 1'b0;
      @(negedge clk);
      chk("after_flush_valid", 32'(out_valid), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("delivered", 32'(n_out), 32'(n_push));
      chk("sb_left", 32'(sb.size()), 32'd0);
      chk("delivered_total", 32'(n_out), 32'd18);

      out_ready = 1'b0;
      send(7);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("rst_mid");
      sb.delete();
      #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

- Decode/issue pipeline stage that produces the ALU's operands `a`, `b` and its 4-bit `alu_op` code from RV32I ALU-class instructions.
- Accepts one instruction per cycle with its PC and register-file read data over a valid/ready handshake.
- Decodes the instruction, selects operands and registers the result into a single-entry stage register that drives the ALU input interface.
- Sits between register-file read and execute; supports back-pressure and flush.

## Interface

Parameters:
- `T`, default 0.000: propagation-delay value, passed unchanged to the `alu_op_decode` sub-module.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `instr`/`pc`/`rs1_data`/`rs2_data` are valid.
- `in_ready` out 1: the stage can accept input this cycle.
- `instr` in 32: instruction word.
- `pc` in 32: instruction address.
- `rs1_data` in 32: rs1 register value.
- `rs2_data` in 32: rs2 register value.
- `flush` in 1: discard the held entry and any input accepted this cycle.
- `out_valid` out 1: issue bundle valid.
- `out_ready` in 1: execute stage accepts the bundle.
- `alu_a` out 32: ALU operand a.
- `alu_b` out 32: ALU operand b.
- `alu_op` out 4: ALU operation code.
- `rd` out 5: destination register (`instr[11:7]`).
- `wb_en` out 1: result is written back.
- `illegal` out 1: instruction not supported by this stage.

## Operation

alu_op codes:
- 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and.
- 0101 sll, 0110 srl, 0111 sra, 1000 sltu.

Decode:
- **OP (0110011):**
  - funct7 = 0000000, funct3 0/1/3/4/5/6/7 → add/sll/sltu/xor/srl/or/and.
  - funct7 = 0100000, funct3 0 → sub; funct3 5 → sra.
  - `a = rs1_data`, `b = rs2_data`.
- **OP-IMM (0010011):** `a = rs1_data`, `b = sign_extend(instr[31:20])`.
  - funct3 0/3/4/6/7 → add/sltu/xor/or/and.
  - funct3 1 → sll; requires `instr[31:25] = 0`.
  - funct3 5 → srl if `instr[31:25] = 0`, sra if `instr[31:25] = 0100000`.
  - The ALU uses only `b[4:0]` for shifts.
- **LUI (0110111):** `a = 0`, `b = {instr[31:12], 12'b0}`, add.
- **AUIPC (0010111):** `a = pc`, `b = {instr[31:12], 12'b0}`, add.
- **Illegal cases:**
  - slt/slti (funct3 2): the ALU has no signed compare.
  - Any other funct7/funct3 combination, or any other opcode.
  - Response: `illegal = 1`, `wb_en = 0`, `alu_op = 0000`, `alu_a = alu_b = 0`.
  - The illegal bundle still flows through the handshake.
- `wb_en = 1` for legal instructions with `rd ≠ 0`; 0 otherwise.

Handshake:
- `in_ready = !out_valid || out_ready` (combinational).
- Input is accepted when `in_valid && in_ready`; the decoded bundle is loaded into the stage register.
- The bundle is consumed when `out_valid && out_ready`.
- Output fields are stable while `out_valid && !out_ready`.

## Timing

- Reset (async assert, sync release): `out_valid = 0`, and `alu_a`, `alu_b`, `alu_op`, `rd`, `wb_en`, `illegal` all 0. `in_ready = 1` while in reset.
- Latency: a bundle accepted in cycle N has `out_valid = 1` in cycle N+1.
- Throughput: one instruction per cycle while `out_ready = 1`.
- Consume and accept in the same cycle: the register reloads with the new bundle and `out_valid` stays 1 (no bubble).
- Consume without accept: `out_valid → 0` next cycle; data fields hold their last values.
- Stall (`out_valid && !out_ready`): `in_ready = 0`; new input is ignored.
- Flush:
  - `flush = 1` forces `out_valid = 0` next cycle, overriding any same-cycle accept.
  - Data fields are not required to clear.
  - `in_ready` is unaffected by `flush` in that cycle.
- Reset asserted mid-stall: the entry is dropped immediately and all outputs return to their reset values.

## Structure

- Shared package `rv32i_pkg`:
  - opcode constants (OP, OP_IMM, LUI, AUIPC);
  - funct3/funct7 constants;
  - the `alu_op` code constants listed above (the ALU control unit uses the same constants);
  - immediate-extraction functions (`imm_i`, `imm_u`).
- Sub-module `alu_op_decode`: purely combinational, `instr` → `alu_op`, `b_sel` (reg/imm_i/imm_u), `a_sel` (rs1/pc/zero), `illegal`.
- The top level holds the operand muxes, the stage register and the handshake logic.

## Test plan

- **Reset:** `rst_n = 0` mid-operation → `out_valid = 0`, all outputs 0, `in_ready = 1`.
- **OP sub:** `instr 0x40208133` (sub x2,x1,x2), `rs1 = 7`, `rs2 = 3` → next cycle `alu_op = 0001`, `a = 7`, `b = 3`, `rd = 2`, `wb_en = 1`.
- **OP-IMM shifts:**
  - srai: `instr 0x4051D193` (srai x3,x3,5) → `alu_op = 0111`, `b[4:0] = 5`.
  - addi: `instr 0xFFF08093` (addi x1,x1,-1) → `b = 0xFFFFFFFF`, `alu_op = 0000`.
- **AUIPC / illegal:**
  - auipc: `instr 0x12345097`, `pc = 0x100` → `a = 0x100`, `b = 0x12345000`, `alu_op = 0000`.
  - slt: `instr 0x0020A033` → `illegal = 1`, `wb_en = 0`.
- **Back-pressure:** stream 4 instructions with `out_ready` low for 3 cycles on the 2nd → `in_ready = 0` during the stall, bundle 2 held stable, all 4 delivered in order with no duplication or loss.
- **Flush:** `flush = 1` in the same cycle as an accept → `out_valid = 0` next cycle; the following accept issues normally one cycle later.
